// File: rtl/npu_buf_pkg.sv
// Shared definitions for the NPU activation stream buffer.
// FSM encoding, default lane-slice width and a lane-enable helper.
package npu_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } buf_state_e;

    localparam int LANE_SLICE_W = 8;

    // A row count of zero selects every lane.
    function automatic logic lane_active(input int lane, input int rows);
        return (rows == 0) ? 1'b1 : (lane < rows);
    endfunction

endpackage

// File: rtl/ram.sv
// Simple dual-port word RAM: one write port, one read port.
// Read data is registered one cycle after the read address; no backpressure.
module ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/skew_delay_line.sv
// Parametrised shift register used to skew one output lane.
// Latency DEPTH cycles (DEPTH=0 is a wire); no backpressure, always shifts.
module skew_delay_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ reset;
            assign dout = din;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        sr[i] <= '0;
                    end
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/a_stream_buffer.sv
// Ping-pong activation buffer streaming ARRAY_N banked lanes (skew via A_STREAM_SKEW_EN).
// Lane n word k appears k+1 (+n when skewed) cycles after the first STREAM cycle; no backpressure.
module a_stream_buffer
    import npu_buf_pkg::*;
#(
    parameter int RAM_SIZE   = 1024,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int ARRAY_N    = 8,
    parameter int ACT_WIDTH  = LANE_SLICE_W,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [LEN_WIDTH-1:0]         length,
    input  logic [$clog2(ARRAY_N):0]     num_rows,
    input  logic                         swap,
    input  logic [ARRAY_N-1:0]           w_en,
    input  logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [ACT_WIDTH-1:0]         w_data,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_half,
    output logic [ARRAY_N-1:0]           act_valid,
    output logic [ARRAY_N*ACT_WIDTH-1:0] act_data
);

`ifdef A_STREAM_SKEW_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif

    localparam int NRW = $clog2(ARRAY_N) + 1;
    localparam int DCW = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(RAM_SIZE - 1);
    localparam logic [DCW-1:0]        DRAIN_LAST = DCW'(ARRAY_N - 1);
    localparam logic [DCW-1:0]        DRAIN_PRE  = DCW'(ARRAY_N - 2);

    buf_state_e            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [NRW-1:0]        rows_q;
    logic [DCW-1:0]        drain_q;
    logic                  swap_pend;
    logic                  rd_en;
    logic                  rd_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            rows_q    <= '0;
            drain_q   <= '0;
            swap_pend <= 1'b0;
            rd_half   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (swap) begin
                        rd_half <= ~rd_half;
                    end
                    if (start && (length != '0)) begin
                        addr_q <= base_addr;
                        rem_q  <= length;
                        rows_q <= num_rows;
                        state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (swap) begin
                        swap_pend <= 1'b1;
                    end
                    addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                    rem_q  <= rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state   <= ST_DRAIN;
                        drain_q <= '0;
                        done    <= (ARRAY_N == 1);
                    end
                end
                ST_DRAIN: begin
                    // A swap arriving in the final DRAIN cycle still lands on IDLE entry.
                    if (drain_q == DRAIN_LAST) begin
                        state     <= ST_IDLE;
                        swap_pend <= 1'b0;
                        if (swap || swap_pend) begin
                            rd_half <= ~rd_half;
                        end
                    end else begin
                        if (swap) begin
                            swap_pend <= 1'b1;
                        end
                        drain_q <= drain_q + 1'b1;
                        done    <= (drain_q == DRAIN_PRE);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state != ST_IDLE);
    assign rd_en = (state == ST_STREAM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
        end
    end

    logic [ARRAY_N-1:0]   we_h  [2];
    logic                 re_h  [2];
    logic [ACT_WIDTH-1:0] rdata [2][ARRAY_N];

    assign we_h[0] = rd_half ? w_en : '0;
    assign we_h[1] = rd_half ? '0 : w_en;
    assign re_h[0] = rd_en & ~rd_half;
    assign re_h[1] = rd_en & rd_half;

    genvar h, n;
    generate
        for (h = 0; h < 2; h++) begin : g_half
            for (n = 0; n < ARRAY_N; n++) begin : g_bank
                ram #(
                    .DEPTH (RAM_SIZE),
                    .WIDTH (ACT_WIDTH),
                    .AW    (ADDR_WIDTH)
                ) u_ram (
                    .clk   (clk),
                    .we    (we_h[h][n]),
                    .waddr (w_addr),
                    .wdata (w_data),
                    .re    (re_h[h]),
                    .raddr (addr_q),
                    .rdata (rdata[h][n])
                );
            end
        end

        for (n = 0; n < ARRAY_N; n++) begin : g_lane
            logic                 lane_on;
            logic [ACT_WIDTH:0]   lane_in;
            logic [ACT_WIDTH:0]   lane_out;

            // Data is zeroed at the source so idle and masked lanes present all-zero.
            assign lane_on = rd_vld && lane_active(n, int'(rows_q));
            assign lane_in = lane_on ? {1'b1, (rd_half ? rdata[1][n] : rdata[0][n])} : '0;

            skew_delay_line #(
                .WIDTH (ACT_WIDTH + 1),
                .DEPTH (SKEW_EN ? n : 0)
            ) u_skew (
                .clk   (clk),
                .reset (reset),
                .din   (lane_in),
                .dout  (lane_out)
            );

            assign act_valid[n]                        = lane_out[ACT_WIDTH];
            assign act_data[n*ACT_WIDTH +: ACT_WIDTH]  = lane_out[ACT_WIDTH-1:0];
        end
    endgenerate

endmodule
